ps2_tx: RTL and testbench
=========================

PS2_TX -- requirements
Module: ps2_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 5000, clk_i cycles PS2_CLK is held low before a request (100 us at 50 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 750000, watchdog limit in clk_i cycles between device clock falling edges (15 ms at 50 MHz).
REQ-003 clk_i  in  1  single clock (CLOCK_50 domain); the only clock.
REQ-004 rst_i  in  1  reset, asynchronous, active-low.
REQ-005 tx_data_i  in  8  command byte to send to the device.
REQ-006 tx_valid_i  in  1  request; the byte transfers when tx_valid_i and tx_ready_o are both high.
REQ-007 tx_ready_o  out  1  high only in IDLE.
REQ-008 ps2_clk_i / ps2_dat_i  in  1 each  raw pin levels (asynchronous).
REQ-009 ps2_clk_oe_o / ps2_dat_oe_o  out  1 each  1 = drive the pin low, 0 = release (open-drain).
REQ-010 tx_done_o  out  1  one-cycle pulse after a frame completes with an acknowledge.
REQ-011 tx_err_o  out  1  one-cycle pulse on a missing acknowledge or a timeout.

Function
REQ-012 The block shall sample ps2_clk_i and ps2_dat_i through 2-FF synchronizers and detect falling edges of ps2_clk on the synchronized value.
REQ-013 On accept, the block shall latch tx_data_i and compute odd parity (parity = XNOR-reduce of the 8 bits).
REQ-014 States and transitions:
- IDLE: accept -> INHIBIT.
- INHIBIT: clk_oe=1 for INHIBIT_CYCLES; then dat_oe=1 (start bit) -> REQ.
- REQ: the next cycle sets clk_oe=0; the first falling edge -> DATA.
- DATA: drive bit0..bit7, LSB first; each bit is driven on the cycle after a falling edge (dat_oe = ~bit); after the 8th bit -> PARITY.
- PARITY: drive parity; the next falling edge -> STOP.
- STOP: dat_oe=0; the next falling edge -> ACK.
- ACK: sample ps2_dat on the next falling edge. Low -> WAIT_IDLE. High -> tx_err_o, IDLE.
- WAIT_IDLE: wait for synchronized clk=1 and dat=1; then tx_done_o, IDLE.
REQ-015 Edge count: exactly 11 device falling edges per frame. A 4-bit bit counter counts 0..10 and never wraps.
REQ-016 The watchdog counter shall be cleared on entry to REQ and on every falling edge, and shall count in REQ through WAIT_IDLE. On reaching TIMEOUT_CYCLES-1 the block shall release both lines, pulse tx_err_o and go to IDLE.
REQ-017 The counter width shall be $clog2(max(INHIBIT_CYCLES, TIMEOUT_CYCLES)). A single counter shall be shared between INHIBIT and the watchdog.
REQ-018 tx_valid_i outside IDLE shall be ignored; there is no queueing.
REQ-019 tx_done_o and tx_err_o shall be mutually exclusive and never asserted in the same cycle.
REQ-020 A falling edge coinciding with a timeout: the timeout takes priority.
REQ-021 The block shall never drive both lines during DATA through WAIT_IDLE except for the data bits; clk_oe shall be 1 only in INHIBIT.

Reset
REQ-022 While rst_i=0, the block shall immediately set state=IDLE, clk_oe=dat_oe=0, tx_ready_o=1, tx_done_o=tx_err_o=0, and clear all counters and synchronizers (synchronizers to 1).
REQ-023 Reset mid-frame shall release both lines asynchronously and shall produce no done or error pulse.

Structure
REQ-024 The shared package (ps2_pkg) shall hold the host command constants (0xED set LEDs, 0xF4 enable, 0xFF reset) and the odd-parity function.
REQ-025 The state enum ps2_tx_state_t shall be local to the module.
REQ-026 Sub-module ps2_sync: 2-FF synchronizer plus falling-edge pulse, reusable by the PS/2 receiver.
REQ-027 Top-level tristate: PS2_CLK = clk_oe ? 0 : 'z (PS2_DAT likewise), implemented outside this module.

Verification (bench: INHIBIT_CYCLES=10, TIMEOUT_CYCLES=200, device model with a 20-cycle clock period)
REQ-028 Send 0xED, device acks -> clk_oe high for 10 cycles; serial bits 1,0,1,1,0,1,1,1 (LSB first), parity 1, stop released; tx_done_o once; tx_ready_o back high.
REQ-029 Send 0xFF, device leaves data high at edge 11 -> parity 1 driven; tx_err_o one pulse; no tx_done_o.
REQ-030 Send 0x00, device never clocks -> tx_err_o exactly 200 cycles after REQ entry; both oe outputs low.
REQ-031 Device stops after 5 edges -> tx_err_o 200 cycles after the 5th edge; tx_valid_i held high throughout -> exactly one accept.
REQ-032 rst_i low during bit 3 -> clk_oe and dat_oe go 0 in the same cycle without a clock edge; no pulses; after release, send 0xF4 -> normal completion with parity 0.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-to-device command bytes and the frame parity helper.
package ps2_pkg;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  // PS/2 frames carry odd parity: the bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizer for a raw PS/2 pin, plus a one-cycle falling-edge pulse.
// Idle level of the bus is high, so every stage resets to 1.
module ps2_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign q_o    = sync_q;
  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-edge frame, ack check.
// state     | meaning
// IDLE      | ready for a byte, both lines released
// INHIBIT   | clock held low for INHIBIT_CYCLES
// REQ       | start bit driven, clock released, waiting for device edge 1
// DATA      | data bits 0..7 driven after each device falling edge
// PARITY    | parity bit driven
// STOP      | data released (stop bit), waiting for edge 11
// ACK       | decide on the acknowledge captured at edge 11
// WAIT_IDLE | wait for both lines high before reporting done
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_dat_oe_o,
  output logic       tx_done_o,
  output logic       tx_err_o
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_INHIBIT, ST_REQ, ST_DATA, ST_PARITY, ST_STOP, ST_ACK, ST_WAIT_IDLE
  } ps2_tx_state_t;

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  ps2_tx_state_t    state_q;
  logic [7:0]       data_q;
  logic             parity_q;
  logic [3:0]       bit_cnt_q;
  logic [CNT_W-1:0] cnt_q;
  logic             clk_oe_q;
  logic             dat_oe_q;
  logic             ready_q;
  logic             done_q;
  logic             err_q;
  logic             ack_q;

  logic clk_s;
  logic clk_fall;
  logic dat_s;
  logic dat_fall_unused;
  logic watch;

  ps2_sync u_sync_clk (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (ps2_clk_i),
    .q_o    (clk_s),
    .fall_o (clk_fall)
  );

  ps2_sync u_sync_dat (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (ps2_dat_i),
    .q_o    (dat_s),
    .fall_o (dat_fall_unused)
  );

  // The shared counter acts as the watchdog from REQ through WAIT_IDLE.
  assign watch = (state_q != ST_IDLE) && (state_q != ST_INHIBIT);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      data_q    <= '0;
      parity_q  <= 1'b0;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (watch && cnt_q == TO_LAST) begin
        state_q  <= ST_IDLE;
        clk_oe_q <= 1'b0;
        dat_oe_q <= 1'b0;
        ready_q  <= 1'b1;
        err_q    <= 1'b1;
      end else begin
        if (watch) cnt_q <= clk_fall ? '0 : cnt_q + 1'b1;
        case (state_q)
          ST_IDLE: begin
            if (tx_valid_i) begin
              data_q    <= tx_data_i;
              parity_q  <= odd_parity(tx_data_i);
              cnt_q     <= '0;
              bit_cnt_q <= '0;
              clk_oe_q  <= 1'b1;
              ready_q   <= 1'b0;
              state_q   <= ST_INHIBIT;
            end
          end
          ST_INHIBIT: begin
            if (cnt_q == INH_LAST) begin
              cnt_q    <= '0;
              clk_oe_q <= 1'b0;
              dat_oe_q <= 1'b1;
              state_q  <= ST_REQ;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          ST_REQ: begin
            if (clk_fall) begin
              dat_oe_q  <= ~data_q[0];
              bit_cnt_q <= 4'd1;
              state_q   <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (clk_fall) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd8) begin
                dat_oe_q <= ~parity_q;
                state_q  <= ST_PARITY;
              end else begin
                dat_oe_q <= ~data_q[bit_cnt_q[2:0]];
              end
            end
          end
          ST_PARITY: begin
            if (clk_fall) begin
              dat_oe_q  <= 1'b0;
              bit_cnt_q <= bit_cnt_q + 4'd1;
              state_q   <= ST_STOP;
            end
          end
          ST_STOP: begin
            // Edge 11 is the last one; the device's ack is already on the line.
            if (clk_fall) begin
              ack_q   <= ~dat_s;
              state_q <= ST_ACK;
            end
          end
          ST_ACK: begin
            if (ack_q) begin
              state_q <= ST_WAIT_IDLE;
            end else begin
              err_q   <= 1'b1;
              ready_q <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
          ST_WAIT_IDLE: begin
            if (clk_s && dat_s) begin
              done_q  <= 1'b1;
              ready_q <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign tx_ready_o   = ready_q;
  assign ps2_clk_oe_o = clk_oe_q;
  assign ps2_dat_oe_o = dat_oe_q;
  assign tx_done_o    = done_q;
  assign tx_err_o     = err_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Directed bench for ps2_tx with an open-drain bus and a simple PS/2 device model.
module tb_ps2_tx;

  localparam int INH = 10;
  localparam int TO  = 200;

  logic       clk_i    = 1'b0;
  logic       rst_i    = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       dev_clk  = 1'b1;
  logic       dev_dat  = 1'b1;
  logic       tx_ready;
  logic       clk_oe;
  logic       dat_oe;
  logic       tx_done;
  logic       tx_err;
  logic       ps2_clk_pin;
  logic       ps2_dat_pin;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int clkoe_cnt = 0;
  int acc_cnt = 0;
  int err_cyc = 0;
  int req_cyc = 0;
  int edge_cyc = 0;
  logic dat_oe_prev = 1'b0;
  logic seen [0:10];

  assign ps2_clk_pin = dev_clk & ~clk_oe;
  assign ps2_dat_pin = dev_dat & ~dat_oe;

  ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .tx_data_i    (tx_data),
    .tx_valid_i   (tx_valid),
    .tx_ready_o   (tx_ready),
    .ps2_clk_i    (ps2_clk_pin),
    .ps2_dat_i    (ps2_dat_pin),
    .ps2_clk_oe_o (clk_oe),
    .ps2_dat_oe_o (dat_oe),
    .tx_done_o    (tx_done),
    .tx_err_o     (tx_err)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    cyc = cyc + 1;
    if (tx_valid && tx_ready) acc_cnt = acc_cnt + 1;
  end

  always @(posedge clk_i) begin
    #1;
    if (tx_done) done_cnt = done_cnt + 1;
    if (tx_err) begin
      err_cnt = err_cnt + 1;
      err_cyc = cyc;
    end
    if (tx_done && tx_err) both_cnt = both_cnt + 1;
    if (clk_oe) clkoe_cnt = clkoe_cnt + 1;
    if (dat_oe && !dat_oe_prev) req_cyc = cyc;
    dat_oe_prev = dat_oe;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk_i);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk_i);
    tx_valid = 1'b0;
  endtask

  // Device: 20-cycle clock period; samples the line just before each falling edge.
  task automatic dev_frame(input int n_edges, input bit ack, output bit ok);
    int n = 0;
    while (!(dat_oe && !clk_oe) && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    ok = (n < 500);
    if (!ok) return;
    for (int k = 0; k < n_edges; k++) begin
      repeat (5) @(negedge clk_i);
      seen[k] = ps2_dat_pin;
      if (k == 10 && ack) dev_dat = 1'b0;
      repeat (5) @(negedge clk_i);
      dev_clk  = 1'b0;
      edge_cyc = cyc;
      repeat (10) @(negedge clk_i);
      dev_clk = 1'b1;
    end
    dev_dat = 1'b1;
  endtask

  task automatic wait_pulse(input int base);
    int n = 0;
    while (done_cnt + err_cnt == base && n < 600) begin
      @(negedge clk_i);
      n++;
    end
  endtask

  initial begin
    bit         ok;
    int         d0;
    int         e0;
    int         a0;
    int         c0;
    int         saved;
    logic [10:0] exp_bits;

    repeat (3) @(negedge clk_i);
    chk("rst_ready", tx_ready, 1);
    chk("rst_clk_oe", clk_oe, 0);
    chk("rst_dat_oe", dat_oe, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_err", tx_err, 0);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // 0xED with acknowledge
    d0 = done_cnt; e0 = err_cnt; c0 = clkoe_cnt;
    send(8'hED);
    dev_frame(11, 1'b1, ok);
    chk("ed_req_seen", ok, 1);
    wait_pulse(d0 + e0);
    repeat (5) @(negedge clk_i);
    exp_bits = {1'b1, 1'b1, 8'hED, 1'b0};
    for (int i = 0; i < 11; i++) chk($sformatf("ed_bit%0d", i), seen[i], exp_bits[i]);
    chk("ed_inhibit_cycles", clkoe_cnt - c0, 10);
    chk("ed_done", done_cnt - d0, 1);
    chk("ed_err", err_cnt - e0, 0);
    chk("ed_ready", tx_ready, 1);

    // 0xFF, device does not acknowledge
    d0 = done_cnt; e0 = err_cnt;
    send(8'hFF);
    dev_frame(11, 1'b0, ok);
    chk("ff_req_seen", ok, 1);
    wait_pulse(d0 + e0);
    repeat (5) @(negedge clk_i);
    chk("ff_parity", seen[9], 1);
    chk("ff_stop", seen[10], 1);
    chk("ff_err", err_cnt - e0, 1);
    chk("ff_done", done_cnt - d0, 0);

    // 0x00, device never clocks
    d0 = done_cnt; e0 = err_cnt;
    send(8'h00);
    wait_pulse(d0 + e0);
    chk("nclk_timeout_cycles", err_cyc - req_cyc, TO);
    chk("nclk_clk_oe", clk_oe, 0);
    chk("nclk_dat_oe", dat_oe, 0);
    repeat (5) @(negedge clk_i);
    chk("nclk_err", err_cnt - e0, 1);
    chk("nclk_done", done_cnt - d0, 0);

    // Device stalls after 5 edges while tx_valid stays high; 2 sync stages + edge flop = 3
    d0 = done_cnt; e0 = err_cnt; a0 = acc_cnt;
    @(negedge clk_i);
    tx_data  = 8'hED;
    tx_valid = 1'b1;
    dev_frame(5, 1'b0, ok);
    chk("stall_req_seen", ok, 1);
    wait_pulse(d0 + e0);
    tx_valid = 1'b0;
    chk("stall_timeout_cycles", err_cyc - edge_cyc, TO + 3);
    repeat (5) @(negedge clk_i);
    chk("stall_accepts", acc_cnt - a0, 1);
    chk("stall_err", err_cnt - e0, 1);
    chk("stall_done", done_cnt - d0, 0);

    // Reset during bit 3 of 0x00, then a clean 0xF4
    d0 = done_cnt; e0 = err_cnt;
    send(8'h00);
    dev_frame(4, 1'b0, ok);
    chk("rstmid_req_seen", ok, 1);
    repeat (2) @(negedge clk_i);
    chk("rstmid_bit3_driven", dat_oe, 1);
    saved = cyc;
    #2 rst_i = 1'b0;
    #1;
    chk("rstmid_clk_oe", clk_oe, 0);
    chk("rstmid_dat_oe", dat_oe, 0);
    chk("rstmid_ready", tx_ready, 1);
    chk("rstmid_no_edge", cyc, saved);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("rstmid_no_done", done_cnt - d0, 0);
    chk("rstmid_no_err", err_cnt - e0, 0);
    send(8'hF4);
    dev_frame(11, 1'b1, ok);
    chk("f4_req_seen", ok, 1);
    wait_pulse(d0 + e0);
    repeat (5) @(negedge clk_i);
    chk("f4_parity", seen[9], 0);
    chk("f4_bit2", seen[3], 1);
    chk("f4_done", done_cnt - d0, 1);
    chk("f4_err", err_cnt - e0, 0);
    chk("done_err_exclusive", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
